// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: state encoding, default reset PC
// and a small helper that forces an address onto a word boundary.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Clear the byte-offset bits so the PC always names a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_counters.sv
// Retired-instruction and taken-branch counters; both wrap modulo 2^32.
module fetch_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        taken,
    output logic [31:0] cnt_inst,
    output logic [31:0] cnt_taken
);

    logic [31:0] cnt_inst_q, cnt_inst_d;
    logic [31:0] cnt_taken_q, cnt_taken_d;

    // Next-count logic: a taken branch only counts when an instruction retires.
    always_comb begin
        cnt_inst_d  = cnt_inst_q;
        cnt_taken_d = cnt_taken_q;
        if (inc) begin
            cnt_inst_d = cnt_inst_q + 32'd1;
            if (taken) begin
                cnt_taken_d = cnt_taken_q + 32'd1;
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_inst_q  <= 32'd0;
            cnt_taken_q <= 32'd0;
        end else begin
            cnt_inst_q  <= cnt_inst_d;
            cnt_taken_q <= cnt_taken_d;
        end
    end

    assign cnt_inst  = cnt_inst_q;
    assign cnt_taken = cnt_taken_q;

endmodule

// File: rtl/fetch_pc.sv
// Fetch stage: holds the PC, issues one instruction-memory read at a time,
// captures the returned word, and waits for the target unit to retire it.
//
// Handshakes:
//   imem_req/imem_ack - imem_req rises in FETCH and stays high (independent
//   of en) until the cycle imem_ack is sampled high; imem_data is taken in
//   that same cycle. imem_ack in any other state is ignored.
//   inst_valid/wtg_valid - inst_valid is high for the whole of EXEC; the
//   instruction retires in the cycle wtg_valid is sampled high, and pc_new,
//   branched and halt are only looked at in that cycle.
module fetch_pc
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_data,
    output logic [31:0]  inst,
    output logic         inst_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pc_4,
    input  logic         wtg_valid,
    input  logic [31:0]  pc_new,
    input  logic         branched,
    input  logic         halt,
    output logic         halted,
    output logic         misalign,
    output logic [31:0]  cnt_inst,
    output logic [31:0]  cnt_taken,
    output fetch_state_e dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         misalign_q, misalign_d;
    logic         retire;

    // Next-state and datapath updates; every input is gated by the state
    // that is allowed to consume it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        misalign_d = misalign_q;
        retire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (wtg_valid) begin
                    retire     = 1'b1;
                    pc_d       = word_align(pc_new);
                    misalign_d = misalign_q | (pc_new[1:0] != 2'b00);
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (en) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC, instruction and sticky misalign registers; reset wins over
    // any in-flight ack or retire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_counters u_counters (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (retire),
        .taken     (branched),
        .cnt_inst  (cnt_inst),
        .cnt_taken (cnt_taken)
    );

    // Status outputs come straight from the state register.
    assign imem_req   = (state_q == ST_FETCH);
    assign inst_valid = (state_q == ST_EXEC);
    assign halted     = (state_q == ST_HALT);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_4       = pc_q + 32'd4;
    assign inst       = inst_q;
    assign misalign   = misalign_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: sequential fetch, taken branch, slow memory,
// halt, PC wrap / misalign and reset collisions.
module tb_fetch_pc;
    import core_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_data;
    logic [31:0]  inst;
    logic         inst_valid;
    logic [31:0]  pc;
    logic [31:0]  pc_4;
    logic         wtg_valid;
    logic [31:0]  pc_new;
    logic         branched;
    logic         halt;
    logic         halted;
    logic         misalign;
    logic [31:0]  cnt_inst;
    logic [31:0]  cnt_taken;
    fetch_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    fetch_pc #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .inst      (inst),
        .inst_valid(inst_valid),
        .pc        (pc),
        .pc_4      (pc_4),
        .wtg_valid (wtg_valid),
        .pc_new    (pc_new),
        .branched  (branched),
        .halt      (halt),
        .halted    (halted),
        .misalign  (misalign),
        .cnt_inst  (cnt_inst),
        .cnt_taken (cnt_taken),
        .dbg_state (dbg_state)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 32'd0;
        wtg_valid = 1'b0;
        pc_new    = 32'd0;
        branched  = 1'b0;
        halt      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Bounded wait for a fetch request; a timeout counts as a failed check.
    task automatic wait_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (imem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s wait_req: imem_req=%b after 30 cycles, required 1", name, imem_req);
        end
    endtask

    task automatic do_ack(input logic [31:0] data);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
        imem_data = 32'hDEAD_BEEF;
    endtask

    task automatic do_retire(input logic [31:0] npc, input logic br, input logic hlt);
        wtg_valid = 1'b1;
        pc_new    = npc;
        branched  = br;
        halt      = hlt;
        tick();
        wtg_valid = 1'b0;
        branched  = 1'b0;
        halt      = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b required 0", inst_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h required 00003000", pc); end
        checks++; if (pc_4 !== 32'h3004) begin errors++; $display("FAIL reset_pc_4: got %h required 00003004", pc_4); end
        checks++; if (inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h required 0", inst); end
        checks++; if (cnt_inst !== 32'd0 || cnt_taken !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", cnt_inst, cnt_taken); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b required 0", misalign); end
        // Idle with en=0 must not request.
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_no_en: got %b required 0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        en = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req_latency: got %b required 1", imem_req); end
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'h3000 + 32'(4 * i);
            wait_req("seq");
            checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr%0d: got %h required %h", i, imem_addr, exp_addr); end
            tick();
            do_ack(32'h0000_0013 + 32'(i));
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_inst_valid%0d: got %b required 1", i, inst_valid); end
            checks++; if (inst !== 32'h0000_0013 + 32'(i)) begin errors++; $display("FAIL seq_inst%0d: got %h required %h", i, inst, 32'h13 + 32'(i)); end
            do_retire(exp_addr + 32'd4, 1'b0, 1'b0);
        end
        checks++; if (cnt_inst !== 32'd3) begin errors++; $display("FAIL seq_cnt_inst: got %0d required 3", cnt_inst); end
        checks++; if (cnt_taken !== 32'd0) begin errors++; $display("FAIL seq_cnt_taken: got %0d required 0", cnt_taken); end
        checks++; if (imem_req !== 1'b1 || pc !== 32'h300C) begin errors++; $display("FAIL seq_next_fetch: req=%b pc=%h required 1/0000300c", imem_req, pc); end
    endtask

    task automatic test_branch();
        wait_req("branch");
        do_ack(32'h0000_0063);
        do_retire(32'h3100, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin errors++; $display("FAIL branch_addr: req=%b addr=%h required 1/00003100", imem_req, imem_addr); end
        checks++; if (cnt_taken !== 32'd1) begin errors++; $display("FAIL branch_cnt_taken: got %0d required 1", cnt_taken); end
        checks++; if (cnt_inst !== 32'd4) begin errors++; $display("FAIL branch_cnt_inst: got %0d required 4", cnt_inst); end
    endtask

    task automatic test_delayed_ack();
        // Already in FETCH at 0x3100; drop en and stall memory for 5 cycles.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL delay_req_held%0d: got %b required 1", i, imem_req); end
            tick();
        end
        do_ack(32'h1234_5678);
        checks++; if (dbg_state !== ST_EXEC || inst !== 32'h1234_5678) begin errors++; $display("FAIL delay_capture: state=%0d inst=%h required %0d/12345678", dbg_state, inst, ST_EXEC); end
        do_retire(32'h3104, 1'b0, 1'b0);
        checks++; if (dbg_state !== ST_IDLE || imem_req !== 1'b0) begin errors++; $display("FAIL delay_to_idle: state=%0d req=%b required %0d/0", dbg_state, imem_req, ST_IDLE); end
        // Retire strobe and ack outside their states must be ignored.
        wtg_valid = 1'b1; pc_new = 32'h5000; branched = 1'b1; imem_ack = 1'b1;
        tick();
        wtg_valid = 1'b0; branched = 1'b0; imem_ack = 1'b0;
        checks++; if (pc !== 32'h3104 || cnt_inst !== 32'd5 || cnt_taken !== 32'd1) begin errors++; $display("FAIL idle_ignore: pc=%h cnt=%0d/%0d required 00003104 5/1", pc, cnt_inst, cnt_taken); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL idle_stays: got %0d required %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_halt();
        en = 1'b1;
        wait_req("halt");
        checks++; if (imem_addr !== 32'h3104) begin errors++; $display("FAIL halt_addr: got %h required 00003104", imem_addr); end
        do_ack(32'h0000_0073);
        do_retire(32'h3108, 1'b0, 1'b1);
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL halt_enter: halted=%b req=%b iv=%b required 1/0/0", halted, imem_req, inst_valid); end
        checks++; if (cnt_inst !== 32'd6) begin errors++; $display("FAIL halt_cnt_inst: got %0d required 6", cnt_inst); end
        imem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wtg_valid = (i % 3 == 0);
            tick();
            checks++; if (imem_req !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold%0d: req=%b halted=%b required 0/1", i, imem_req, halted); end
        end
        imem_ack = 1'b0; wtg_valid = 1'b0;
        checks++; if (cnt_inst !== 32'd6 || pc !== 32'h3108) begin errors++; $display("FAIL halt_frozen: cnt=%0d pc=%h required 6/00003108", cnt_inst, pc); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (dbg_state !== ST_IDLE || pc !== RST_PC || halted !== 1'b0) begin errors++; $display("FAIL halt_reset: state=%0d pc=%h halted=%b required %0d/00003000/0", dbg_state, pc, halted, ST_IDLE); end
    endtask

    task automatic test_wrap_misalign();
        apply_reset();
        en = 1'b1;
        wait_req("wrap");
        do_ack(32'h0000_0001);
        do_retire(32'hFFFF_FFFC, 1'b0, 1'b0);
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h required fffffffc", pc); end
        checks++; if (pc_4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc_4: got %h required 00000000", pc_4); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL wrap_misalign: got %b required 0", misalign); end
        wait_req("misalign");
        do_ack(32'h0000_0002);
        do_retire(32'h3002, 1'b0, 1'b0);
        checks++; if (pc !== 32'h3000 || misalign !== 1'b1) begin errors++; $display("FAIL misalign_set: pc=%h mis=%b required 00003000/1", pc, misalign); end
        wait_req("sticky");
        do_ack(32'h0000_0003);
        do_retire(32'h3004, 1'b0, 1'b0);
        checks++; if (pc !== 32'h3004 || misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky: pc=%h mis=%b required 00003004/1", pc, misalign); end
        apply_reset();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_reset: got %b required 0", misalign); end
    endtask

    task automatic test_reset_collision();
        en = 1'b1;
        wait_req("coll_ack");
        // Reset lands on the same edge as the ack.
        imem_ack = 1'b1; imem_data = 32'hCAFE_F00D; rst_n = 1'b0;
        tick();
        imem_ack = 1'b0; rst_n = 1'b1;
        checks++; if (dbg_state !== ST_IDLE || inst !== 32'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL coll_ack: state=%0d inst=%h req=%b required %0d/0/0", dbg_state, inst, imem_req, ST_IDLE); end
        wait_req("coll_wtg1");
        do_ack(32'h0000_00AA);
        do_retire(32'h3008, 1'b1, 1'b0);
        checks++; if (cnt_inst !== 32'd1 || cnt_taken !== 32'd1) begin errors++; $display("FAIL coll_pre: cnt=%0d/%0d required 1/1", cnt_inst, cnt_taken); end
        wait_req("coll_wtg2");
        do_ack(32'h0000_00BB);
        // Reset lands on the same edge as the retire strobe.
        wtg_valid = 1'b1; pc_new = 32'h4000; branched = 1'b1; rst_n = 1'b0;
        tick();
        wtg_valid = 1'b0; branched = 1'b0; rst_n = 1'b1;
        checks++; if (cnt_inst !== 32'd0 || cnt_taken !== 32'd0) begin errors++; $display("FAIL coll_wtg_cnt: got %0d/%0d required 0/0", cnt_inst, cnt_taken); end
        checks++; if (dbg_state !== ST_IDLE || inst !== 32'd0 || pc !== RST_PC) begin errors++; $display("FAIL coll_wtg_state: state=%0d inst=%h pc=%h required %0d/0/00003000", dbg_state, inst, pc, ST_IDLE); end
    endtask

    // Scenario sequence and final report
    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_delayed_ack();
        test_halt();
        test_wrap_misalign();
        test_reset_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  run enable; gates start of a new fetch.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address, equals pc.
REQ-007 imem_ack  input  1  memory read complete; imem_data valid this cycle.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 inst  output  32  captured instruction for decode.
REQ-010 inst_valid  output  1  inst held for execution.
REQ-011 pc  output  32  address of current instruction.
REQ-012 pc_4  output  32  pc + 4, to branch/jump target unit.
REQ-013 wtg_valid  input  1  pc_new/branched valid; instruction retires.
REQ-014 pc_new  input  32  next PC from target unit.
REQ-015 branched  input  1  retiring instruction took a conditional branch.
REQ-016 halt  input  1  retiring instruction is a halt.
REQ-017 halted  output  1  core stopped.
REQ-018 misalign  output  1  sticky: some pc_new had nonzero bits [1:0].
REQ-019 cnt_inst  output  32  retired-instruction count.
REQ-020 cnt_taken  output  32  taken-branch count.

Function
REQ-021 States: IDLE, FETCH, EXEC, HALT; one-hot or binary, encoding from package.
REQ-022 IDLE: en=1 -> FETCH next cycle; en=0 -> stay.
REQ-023 FETCH: imem_req=1, imem_addr=pc; on imem_ack inst<=imem_data, -> EXEC; request held until ack regardless of en.
REQ-024 EXEC: inst_valid=1; on wtg_valid: pc<={pc_new[31:2],2'b00}, cnt_inst+=1, cnt_taken+=branched, misalign|= (pc_new[1:0]!=0).
REQ-025 EXEC exit on wtg_valid: halt=1 -> HALT; else en=1 -> FETCH; else IDLE.
REQ-026 HALT: halted=1, imem_req=0, inst_valid=0; exit only by reset.
REQ-027 imem_ack outside FETCH, wtg_valid/halt/branched outside EXEC: ignored, no state change.
REQ-028 Latency: ack cycle N -> inst_valid from N+1; wtg_valid cycle M -> new pc visible M+1, imem_req for it M+1 if en.
REQ-029 pc_4 combinational, = pc + 32'd4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-030 Counters wrap modulo 2^32; no saturation.
REQ-031 imem_req, inst_valid, halted decoded from state only (no input-to-output path).

Reset
REQ-032 rst_n=0 at clock edge: state<=IDLE, pc<=RESET_PC, inst<=0, cnt_inst<=0, cnt_taken<=0, misalign<=0.
REQ-033 Reset dominates all inputs, including mid-FETCH ack and mid-EXEC wtg_valid; outstanding request dropped.
REQ-034 During and after reset until leaving IDLE: imem_req=0, inst_valid=0, halted=0, pc_4=RESET_PC+4.

Structure
REQ-035 Shared package core_pkg holds fetch state encoding and default RESET_PC constant.
REQ-036 Counters implemented in sub-module fetch_counters (clk, rst_n, inc, taken, cnt_inst, cnt_taken).
REQ-037 No other sub-modules; no memories inside the block.

Verification
REQ-038 Reset RESET_PC=0x3000, en=1, ack 1 cycle after req, pc_new=pc_4 x3 -> addrs 0x3000,0x3004,0x3008; cnt_inst=3, cnt_taken=0.
REQ-039 EXEC with pc_new=0x3100, branched=1 -> next imem_addr=0x3100, cnt_taken=1.
REQ-040 ack delayed 5 cycles with en dropped during FETCH -> req held 5 cycles, inst captured, EXEC entered; after retire -> IDLE.
REQ-041 halt=1 with wtg_valid -> halted=1 next cycle, no req for 20 cycles despite en=1 and spurious ack; rst_n=0 -> IDLE, pc=RESET_PC.
REQ-042 pc=0xFFFF_FFFC -> pc_4=0; pc_new=0x3002 -> pc=0x3000, misalign=1 sticky until reset.
REQ-043 rst_n=0 same cycle as imem_ack and as wtg_valid -> counters 0, state IDLE, inst=0.
